// File: rtl/fizz_buzz_pkg.sv
// Shared selector codes, ASCII constants, FSM states and FIFO entry layout
// for the Fizz Buzz ASCII line formatter.
package fizz_buzz_pkg;

    localparam logic [2:0] FB_NONE     = 3'b000;
    localparam logic [2:0] FB_FIZZ     = 3'b001;
    localparam logic [2:0] FB_BUZZ     = 3'b010;
    localparam logic [2:0] FB_FIZZBUZZ = 3'b100;

    localparam logic [7:0] ASCII_F      = 8'h46;
    localparam logic [7:0] ASCII_I      = 8'h69;
    localparam logic [7:0] ASCII_Z      = 8'h7A;
    localparam logic [7:0] ASCII_B      = 8'h42;
    localparam logic [7:0] ASCII_U      = 8'h75;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT0 = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONV     = 3'd1,
        ST_EMIT_TXT = 3'd2,
        ST_EMIT_DIG = 3'd3,
        ST_EMIT_EOL = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0]  fizzbuzz;
        logic [31:0] data;
    } fifo_entry_t;

    // Raw selector may have several bits set; the highest one wins.
    function automatic logic [2:0] decode_sel(input logic [2:0] raw);
        logic [2:0] sel;
        if (raw[2]) begin
            sel = FB_FIZZBUZZ;
        end else if (raw[1]) begin
            sel = FB_BUZZ;
        end else if (raw[0]) begin
            sel = FB_FIZZ;
        end else begin
            sel = FB_NONE;
        end
        return sel;
    endfunction

    function automatic logic [7:0] text_byte(input logic [2:0] sel, input logic [3:0] idx);
        logic       buzz_half;
        logic [7:0] b;
        buzz_half = (sel == FB_BUZZ) || ((sel == FB_FIZZBUZZ) && idx[2]);
        case (idx[1:0])
            2'd0:    b = buzz_half ? ASCII_B : ASCII_F;
            2'd1:    b = buzz_half ? ASCII_U : ASCII_I;
            default: b = ASCII_Z;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] bcd_ascii(input logic [39:0] bcd, input logic [3:0] idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            d = (idx == 4'(i)) ? bcd[4*i +: 4] : d;
        end
        return ASCII_DIGIT0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/fizz_buzz_bin2bcd.sv
// Iterative 32-bit binary to 10-digit BCD converter (double dabble):
// one bit per clock, done pulses for one cycle after the 32nd shift.
module fizz_buzz_bin2bcd (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [39:0] bcd_o
);

    logic [39:0] bcd_q, bcd_d, bcd_adj_s;
    logic [31:0] bin_q, bin_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Add-3 correction on each digit, then shift the next binary bit in.
    always_comb begin
        bcd_adj_s = bcd_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        if (start_i) begin
            bcd_d  = 40'd0;
            bin_d  = bin_i;
            cnt_d  = 5'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            {bcd_d, bin_d} = {bcd_adj_s, bin_q} << 1;
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Conversion state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bcd_q  <= 40'd0;
            bin_q  <= 32'd0;
            cnt_q  <= 5'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/fizz_buzz_ascii.sv
// Fizz Buzz result-to-ASCII line formatter: input FIFO, line FSM and a
// registered valid/ready byte stream toward a console sink.
module fizz_buzz_ascii
    import fizz_buzz_pkg::*;
#(
    parameter int FIFO_DEPTH = 128,
    parameter int EOL_CRLF   = 0
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        SINK_VALID,
    input  logic [31:0] SINK_DATA,
    input  logic [2:0]  SINK_FIZZBUZZ,
    output logic        SINK_READY,
    output logic        SOURCE_VALID,
    output logic [7:0]  SOURCE_DATA,
    output logic        SOURCE_LAST,
    input  logic        SOURCE_READY,
    output logic        OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    fifo_entry_t   mem_q [FIFO_DEPTH];
    fifo_entry_t   head_s, wr_entry_s;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          empty_s, full_s, full_d_s, push_s, pop_s, drop_s;
    logic [2:0]    head_sel_s;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [3:0]    idx_q, idx_d, msd_s, last_txt_idx_s;
    logic          src_valid_q, src_valid_d, src_last_q, src_last_d;
    logic [7:0]    src_data_q, src_data_d;
    logic          sink_ready_q, overflow_q;
    logic          fire_s, take_s, eol_s;
    logic          bcd_start_s, bcd_busy_s, bcd_done_s;
    logic [39:0]   bcd_s;

    // Extra pointer bit distinguishes full from empty; a pop frees a slot in the same cycle.
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_s   = SINK_VALID && (!full_s || pop_s);
    assign drop_s   = SINK_VALID && full_s && !pop_s;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_s};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_s};
    assign full_d_s = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    assign head_s              = mem_q[rd_ptr_q[AW-1:0]];
    assign head_sel_s          = decode_sel(head_s.fizzbuzz);
    assign wr_entry_s.fizzbuzz = SINK_FIZZBUZZ;
    assign wr_entry_s.data     = SINK_DATA;

    fizz_buzz_bin2bcd u_bin2bcd (
        .clk_i   (CLK),
        .rst_n_i (RESET_n),
        .start_i (bcd_start_s),
        .bin_i   (head_s.data),
        .busy_o  (bcd_busy_s),
        .done_o  (bcd_done_s),
        .bcd_o   (bcd_s)
    );

    // Line FSM: the output register always holds the byte the current state is presenting.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        idx_d          = idx_q;
        src_valid_d    = src_valid_q;
        src_data_d     = src_data_q;
        src_last_d     = src_last_q;
        pop_s          = 1'b0;
        bcd_start_s    = 1'b0;
        take_s         = 1'b0;
        eol_s          = 1'b0;
        fire_s         = src_valid_q && SOURCE_READY;
        last_txt_idx_s = (sel_q == FB_FIZZBUZZ) ? 4'd7 : 4'd3;
        msd_s          = 4'd0;
        for (int i = 0; i < 10; i++) begin
            msd_s = (bcd_s[4*i +: 4] != 4'd0) ? 4'(i) : msd_s;
        end

        case (state_q)
            ST_IDLE: begin
                take_s = !empty_s;
            end
            ST_CONV: begin
                if (bcd_done_s && !bcd_busy_s) begin
                    state_d     = ST_EMIT_DIG;
                    idx_d       = msd_s;
                    src_valid_d = 1'b1;
                    src_data_d  = bcd_ascii(bcd_s, msd_s);
                    src_last_d  = 1'b0;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_EMIT_TXT: begin
                if (fire_s && (idx_q == last_txt_idx_s)) begin
                    eol_s = 1'b1;
                end else if (fire_s) begin
                    idx_d      = idx_q + 4'd1;
                    src_data_d = text_byte(sel_q, idx_q + 4'd1);
                end else begin
                    state_d = ST_EMIT_TXT;
                end
            end
            ST_EMIT_DIG: begin
                if (fire_s && (idx_q == 4'd0)) begin
                    eol_s = 1'b1;
                end else if (fire_s) begin
                    idx_d      = idx_q - 4'd1;
                    src_data_d = bcd_ascii(bcd_s, idx_q - 4'd1);
                end else begin
                    state_d = ST_EMIT_DIG;
                end
            end
            ST_EMIT_EOL: begin
                if (fire_s && src_last_q) begin
                    take_s      = !empty_s;
                    state_d     = ST_IDLE;
                    src_valid_d = 1'b0;
                    src_data_d  = 8'h00;
                    src_last_d  = 1'b0;
                end else if (fire_s) begin
                    src_data_d = ASCII_LF;
                    src_last_d = 1'b1;
                end else begin
                    state_d = ST_EMIT_EOL;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                src_valid_d = 1'b0;
                src_data_d  = 8'h00;
                src_last_d  = 1'b0;
            end
        endcase

        if (eol_s) begin
            state_d    = ST_EMIT_EOL;
            src_data_d = (EOL_CRLF != 0) ? ASCII_CR : ASCII_LF;
            src_last_d = (EOL_CRLF == 0);
        end else begin
            src_last_d = src_last_d;
        end

        // Pop straight from IDLE or from the final LF, so back-to-back lines have no bubble.
        if (take_s && (head_sel_s != FB_NONE)) begin
            pop_s       = 1'b1;
            state_d     = ST_EMIT_TXT;
            sel_d       = head_sel_s;
            idx_d       = 4'd0;
            src_valid_d = 1'b1;
            src_data_d  = text_byte(head_sel_s, 4'd0);
            src_last_d  = 1'b0;
        end else if (take_s) begin
            pop_s       = 1'b1;
            bcd_start_s = 1'b1;
            state_d     = ST_CONV;
            src_valid_d = 1'b0;
            src_last_d  = 1'b0;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Control, pointer and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= FB_NONE;
            idx_q        <= 4'd0;
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            src_valid_q  <= 1'b0;
            src_data_q   <= 8'h00;
            src_last_q   <= 1'b0;
            sink_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            src_valid_q  <= src_valid_d;
            src_data_q   <= src_data_d;
            src_last_q   <= src_last_d;
            sink_ready_q <= !full_d_s;
            overflow_q   <= overflow_q || drop_s;
        end
    end

    // FIFO storage; pointers alone define occupancy, so the array needs no reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_s;
        end
    end

    assign SINK_READY   = sink_ready_q;
    assign SOURCE_VALID = src_valid_q;
    assign SOURCE_DATA  = src_data_q;
    assign SOURCE_LAST  = src_last_q;
    assign OVERFLOW     = overflow_q;

endmodule

// File: tb/tb_fizz_buzz_ascii.sv
// Scoreboard bench for fizz_buzz_ascii: one default LF instance and one
// small-FIFO CR LF instance, each compared byte-by-byte against a text model.
module tb_fizz_buzz_ascii;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_sink_valid, a_sink_ready, a_src_valid, a_src_last, a_src_ready, a_overflow;
    logic [31:0] a_sink_data;
    logic [2:0]  a_sink_fb;
    logic [7:0]  a_src_data;
    logic        b_rst_n, b_sink_valid, b_sink_ready, b_src_valid, b_src_last, b_src_ready, b_overflow;
    logic [31:0] b_sink_data;
    logic [2:0]  b_sink_fb;
    logic [7:0]  b_src_data;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [8:0] a_hold, b_hold;
    bit         a_stall = 1'b0, b_stall = 1'b0;

    fizz_buzz_ascii #(.FIFO_DEPTH(128), .EOL_CRLF(0)) dut_a (
        .CLK(clk), .RESET_n(a_rst_n), .SINK_VALID(a_sink_valid), .SINK_DATA(a_sink_data),
        .SINK_FIZZBUZZ(a_sink_fb), .SINK_READY(a_sink_ready), .SOURCE_VALID(a_src_valid),
        .SOURCE_DATA(a_src_data), .SOURCE_LAST(a_src_last), .SOURCE_READY(a_src_ready),
        .OVERFLOW(a_overflow));

    fizz_buzz_ascii #(.FIFO_DEPTH(4), .EOL_CRLF(1)) dut_b (
        .CLK(clk), .RESET_n(b_rst_n), .SINK_VALID(b_sink_valid), .SINK_DATA(b_sink_data),
        .SINK_FIZZBUZZ(b_sink_fb), .SINK_READY(b_sink_ready), .SOURCE_VALID(b_src_valid),
        .SOURCE_DATA(b_src_data), .SOURCE_LAST(b_src_last), .SOURCE_READY(b_src_ready),
        .OVERFLOW(b_overflow));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit to_b, input logic [8:0] e);
        if (to_b) exp_b.push_back(e);
        else      exp_a.push_back(e);
    endtask

    // Reference text model: decimal digits come from repeated division, not BCD.
    task automatic add_line(input bit to_b, input logic [2:0] sel, input logic [31:0] v);
        logic [7:0]  txt[$];
        int unsigned digs[$];
        int unsigned x;
        logic [63:0] w;
        if (sel[2] || sel[1] || sel[0]) begin
            if (sel[2])      w = 64'h46697A7A_42757A7A;
            else if (sel[1]) w = 64'h42757A7A_00000000;
            else             w = 64'h46697A7A_00000000;
            for (int k = 7; k >= 0; k--) begin
                if (w[8*k +: 8] != 8'h00) txt.push_back(w[8*k +: 8]);
            end
        end else begin
            x = v;
            do begin
                digs.push_front(x % 10);
                x = x / 10;
            end while (x != 0);
            foreach (digs[k]) txt.push_back(8'h30 + 8'(digs[k]));
        end
        if (to_b) txt.push_back(8'h0D);
        foreach (txt[k]) push_exp(to_b, {1'b0, txt[k]});
        push_exp(to_b, {1'b1, 8'h0A});
    endtask

    task automatic push_a(input logic [2:0] sel, input logic [31:0] v);
        a_sink_valid = 1'b1; a_sink_fb = sel; a_sink_data = v;
        add_line(1'b0, sel, v);
        tick();
        a_sink_valid = 1'b0;
    endtask

    task automatic push_b(input logic [2:0] sel, input logic [31:0] v, input bit kept);
        b_sink_valid = 1'b1; b_sink_fb = sel; b_sink_data = v;
        if (kept) add_line(1'b1, sel, v);
        tick();
        b_sink_valid = 1'b0;
    endtask

    task automatic measure(input bit to_b, input string tag, input int exp_lat);
        int n = 0;
        while (!(to_b ? b_src_valid : a_src_valid) && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp_lat));
    endtask

    task automatic drain(input bit to_b, input bit rnd, input int budget);
        int n = 0;
        while (((to_b ? exp_b.size() : exp_a.size()) != 0) && n < budget) begin
            if (rnd && !to_b) a_src_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (!to_b) a_src_ready = 1'b1;
        check(to_b ? "b_drain" : "a_drain", 32'(to_b ? exp_b.size() : exp_a.size()), 32'd0);
        tick();
        check(to_b ? "b_idle_valid" : "a_idle_valid", 32'(to_b ? b_src_valid : a_src_valid), 32'd0);
    endtask

    // Scoreboard pop on each byte that will transfer at the next rising edge, plus stall-hold checks.
    always @(negedge clk) begin
        if (a_rst_n) begin
            if (a_stall) begin
                check("a_hold_valid", 32'(a_src_valid), 32'd1);
                check("a_hold_byte", 32'({a_src_last, a_src_data}), 32'(a_hold));
            end
            if (a_src_valid && a_src_ready) begin
                if (exp_a.size() == 0) check("a_unexpected_byte", 32'({a_src_last, a_src_data}), 32'h1FF);
                else                   check("a_byte", 32'({a_src_last, a_src_data}), 32'(exp_a.pop_front()));
            end
            a_stall = a_src_valid && !a_src_ready;
            a_hold  = {a_src_last, a_src_data};
        end else begin
            a_stall = 1'b0;
        end
        if (b_rst_n) begin
            if (b_stall) begin
                check("b_hold_valid", 32'(b_src_valid), 32'd1);
                check("b_hold_byte", 32'({b_src_last, b_src_data}), 32'(b_hold));
            end
            if (b_src_valid && b_src_ready) begin
                if (exp_b.size() == 0) check("b_unexpected_byte", 32'({b_src_last, b_src_data}), 32'h1FF);
                else                   check("b_byte", 32'({b_src_last, b_src_data}), 32'(exp_b.pop_front()));
            end
            b_stall = b_src_valid && !b_src_ready;
            b_hold  = {b_src_last, b_src_data};
        end else begin
            b_stall = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [2:0]  bsel [6];
        logic [31:0] bval [6];
        a_rst_n = 1'b0; a_sink_valid = 1'b0; a_sink_data = 32'd0; a_sink_fb = 3'd0; a_src_ready = 1'b0;
        b_rst_n = 1'b0; b_sink_valid = 1'b0; b_sink_data = 32'd0; b_sink_fb = 3'd0; b_src_ready = 1'b0;
        repeat (3) tick();
        check("rst_a_valid", 32'(a_src_valid), 32'd0);
        check("rst_a_data", 32'(a_src_data), 32'd0);
        check("rst_a_last", 32'(a_src_last), 32'd0);
        check("rst_a_overflow", 32'(a_overflow), 32'd0);
        check("rst_a_sink_ready", 32'(a_sink_ready), 32'd0);
        check("rst_b_sink_ready", 32'(b_sink_ready), 32'd0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
        check("a_sink_ready_after_rst", 32'(a_sink_ready), 32'd1);
        check("b_sink_ready_after_rst", 32'(b_sink_ready), 32'd1);

        // FizzBuzz text line and decimal lines with latency
        a_src_ready = 1'b1;
        push_a(3'b100, 32'd15);
        measure(1'b0, "a_lat_fizzbuzz", 1);
        drain(1'b0, 1'b0, 200);
        push_a(3'b000, 32'd0);
        measure(1'b0, "a_lat_dec0", 34);
        drain(1'b0, 1'b0, 200);
        push_a(3'b000, 32'd7);
        measure(1'b0, "a_lat_dec7", 34);
        drain(1'b0, 1'b0, 200);
        push_a(3'b000, 32'hFFFF_FFFF);
        measure(1'b0, "a_lat_decmax", 34);
        drain(1'b0, 1'b0, 200);

        // Selector priority with multiple bits set
        push_a(3'b111, 32'd9);
        push_a(3'b011, 32'd10);
        push_a(3'b110, 32'd30);
        drain(1'b0, 1'b0, 300);

        // Back-to-back generator run 1..100
        for (int i = 1; i <= 100; i++) begin
            push_a((i % 15 == 0) ? 3'b100 : (i % 5 == 0) ? 3'b010 : (i % 3 == 0) ? 3'b001 : 3'b000, 32'(i));
        end
        drain(1'b0, 1'b0, 10000);
        check("a_overflow_after_run", 32'(a_overflow), 32'd0);

        // Stall mid "Buzz", then random READY
        a_src_ready = 1'b0;
        push_a(3'b010, 32'd5);
        measure(1'b0, "a_lat_buzz", 1);
        check("a_first_buzz_byte", 32'(a_src_data), 32'h42);
        a_src_ready = 1'b1;
        tick();
        a_src_ready = 1'b0;
        repeat (5) begin
            tick();
            check("a_stall_data", 32'(a_src_data), 32'h75);
        end
        push_a(3'b000, 32'd12345);
        push_a(3'b001, 32'd3);
        drain(1'b0, 1'b1, 3000);

        // Reset during conversion discards the line
        push_a(3'b000, 32'd99);
        repeat (5) tick();
        check("a_conv_valid", 32'(a_src_valid), 32'd0);
        exp_a.delete();
        a_rst_n = 1'b0;
        tick();
        check("a_midrst_valid", 32'(a_src_valid), 32'd0);
        check("a_midrst_sink_ready", 32'(a_sink_ready), 32'd0);
        a_rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (a_src_valid) seen++;
        end
        check("a_no_byte_after_rst", 32'(seen), 32'd0);
        check("a_sink_ready_post_rst", 32'(a_sink_ready), 32'd1);
        push_a(3'b001, 32'd6);
        measure(1'b0, "a_lat_after_rst", 1);
        drain(1'b0, 1'b0, 200);

        // Small FIFO overflow with CR LF endings
        b_src_ready = 1'b0;
        push_b(3'b001, 32'd3, 1'b1);
        measure(1'b1, "b_lat_fizz", 1);
        bsel = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
        bval = '{32'd5, 32'd7, 32'd15, 32'd8, 32'd22, 32'd23};
        for (int k = 0; k < 6; k++) begin
            push_b(bsel[k], bval[k], k < 4);
            check("b_sink_ready_burst", 32'(b_sink_ready), (k < 3) ? 32'd1 : 32'd0);
            check("b_overflow_burst", 32'(b_overflow), (k >= 4) ? 32'd1 : 32'd0);
        end
        b_src_ready = 1'b1;
        drain(1'b1, 1'b0, 1000);
        repeat (50) tick();
        check("b_overflow_sticky", 32'(b_overflow), 32'd1);
        check("b_sink_ready_end", 32'(b_sink_ready), 32'd1);
        check("b_valid_end", 32'(b_src_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fizz_buzz_ascii.md
Name: fizz_buzz_ascii

Overview:
Downstream stage of the Fizz Buzz generator. It consumes the generator's per-count result stream (value plus Fizz/Buzz/FizzBuzz selector) and turns each result into an ASCII text line ("Fizz", "Buzz", "FizzBuzz" or the decimal number, then end-of-line). The line bytes leave on a valid/ready byte stream toward a UART/console sink. The generator has no backpressure, so an input FIFO absorbs its one-result-per-cycle burst.

Parameters:
FIFO_DEPTH, 128, input FIFO entries; power of two ≥2; default holds a full 100-count run.
EOL_CRLF, 0, 0: line ends with LF (0x0A); 1: line ends with CR LF (0x0D 0x0A).

Ports:
CLK  in  1  clock, all logic on rising edge
RESET_n  in  1  reset, synchronous, active-low
SINK_VALID  in  1  result valid; connects to generator SOURCE_VALID
SINK_DATA  in  32  result count value, unsigned
SINK_FIZZBUZZ  in  3  selector: bit2 FizzBuzz, bit1 Buzz, bit0 Fizz
SINK_READY  out  1  FIFO not full (status only; generator does not use it)
SOURCE_VALID  out  1  output byte valid
SOURCE_DATA  out  8  output ASCII byte
SOURCE_LAST  out  1  high on the final end-of-line byte of each line
SOURCE_READY  in  1  downstream accepts byte
OVERFLOW  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset is synchronous, active-low, and fixed. While RESET_n=0 at a clock edge: FIFO emptied; FSM to IDLE; converter cleared. SOURCE_VALID=0, SOURCE_DATA=0x00, SOURCE_LAST=0, OVERFLOW=0, SINK_READY=0. SINK_READY=1 from the first edge after reset release.
- A mid-line reset discards the partial line. No byte is emitted after reset until a new result is written.
- Write: when SINK_VALID=1 and the FIFO is not full, {SINK_FIZZBUZZ, SINK_DATA} is pushed. When full, the result is dropped and OVERFLOW is set; OVERFLOW clears only on reset. A simultaneous push and pop on a full FIFO is allowed and is not an overflow.
- Selector decode uses priority bit2 > bit1 > bit0: FizzBuzz, Buzz, Fizz. Selector 000 selects decimal.
- FSM states:
  - IDLE: FIFO non-empty → pop; text → EMIT_TXT; decimal → CONV.
  - CONV: 32-cycle shift-add-3 binary-to-BCD, then 1 cycle to locate the most significant non-zero digit. Value 0 yields the single digit "0". Then → EMIT_DIG.
  - EMIT_TXT / EMIT_DIG: one byte per accepted handshake, MSB digit first. Leading zeros are suppressed; there are at most 10 digits (4294967295).
  - EMIT_EOL: CR (if EOL_CRLF) then LF. SOURCE_LAST=1 on LF. On LF acceptance → pop the next entry if the FIFO is non-empty (no bubble), else → IDLE.
- Latency, with the pop at cycle N:
  - text: first byte valid at N+1.
  - decimal: first byte valid at N+34.
- Handshake: a byte transfers on an edge with SOURCE_VALID & SOURCE_READY. While VALID=1 and READY=0, DATA and LAST hold stable. VALID never drops before acceptance. VALID does not depend combinationally on READY.
- Text bytes:
  - Fizz = 46 69 7A 7A
  - Buzz = 42 75 7A 7A
  - FizzBuzz = 46 69 7A 7A 42 75 7A 7A
- Digits are 0x30 + BCD nibble.

Decomposition:
- Package fizz_buzz_pkg:
  - selector constants FB_FIZZ=3'b001, FB_BUZZ=3'b010, FB_FIZZBUZZ=3'b100;
  - ASCII constants (text bytes, CR, LF, digit base);
  - FSM state enum;
  - FIFO entry struct {fizzbuzz, data}.
- Sub-module fizz_buzz_bin2bcd: iterative 32-bit double-dabble with start/busy/done and a 40-bit BCD output.
- The FIFO stays inline as a simple register/RAM with read/write pointers.

Test Plan:
- Push {100, 32'd15}, READY=1 → bytes 46 69 7A 7A 42 75 7A 7A 0A on consecutive cycles; first byte 1 cycle after pop; LAST only on 0A.
- Push decimals 0, 7, 4294967295 → "0\n" (30 0A), "7\n" (37 0A), "4294967295\n" (34 32 39 34 39 36 37 32 39 35 0A); first byte 34 cycles after pop.
- Generator run 1..100 back-to-back, READY=1 → 100 lines "1","2","Fizz","4","Buzz",…,"FizzBuzz" (15), …,"Buzz" (100); OVERFLOW stays 0.
- Hold READY=0 for 5 cycles mid "Buzz" (after 42 accepted), then random READY → DATA held at 75 while stalled; byte sequence has no loss or duplication.
- FIFO_DEPTH=4, READY=0, push 6 results → SINK_READY=0 after the 4th; OVERFLOW=1 on the 5th; after READY=1 exactly the first 4 lines appear.
- EOL_CRLF=1 with Fizz → 46 69 7A 7A 0D 0A, LAST on 0A; reset asserted during CONV → next edge VALID=0, FIFO empty; the next pushed result emits cleanly.
